// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunk-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder; also exposes the carry into the MSB for signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  always_comb begin
    logic [CHUNK:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[CHUNK];
    cmsb = c[CHUNK-1];
  end

endmodule

// File: rtl/seq_addsub.sv
// Chunk-serial two's-complement add/sub with valid/ready handshakes on both sides.
// Define ADDSUB_SAT_EN to clamp signed-overflow results to the most positive/negative value.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cbout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt, final_res;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             last;
  logic             ovf_w;
  int               base;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             cout_chunk, cmsb_chunk;

`ifdef ADDSUB_SAT_EN
  // Overflow with no carry out of the MSB can only come from two positives.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                input logic ovf_f,
                                                input logic cout_f);
    if (!ovf_f)
      return val;
    if (!cout_f)
      return {1'b0, {(WIDTH-1){1'b1}}};
    return {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (idx == IDX_W'(NCHUNK - 1));

  always_comb begin
    base    = int'(idx) * CHUNK;
    a_chunk = op_a[base +: CHUNK];
    b_chunk = op_b[base +: CHUNK];
    acc_nxt = acc;
    acc_nxt[base +: CHUNK] = sum_chunk;
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .sum  (sum_chunk),
    .cout (cout_chunk),
    .cmsb (cmsb_chunk)
  );

  assign ovf_w = cmsb_chunk ^ cout_chunk;

`ifdef ADDSUB_SAT_EN
  assign final_res = saturate(acc_nxt, ovf_w, cout_chunk);
`else
  assign final_res = acc_nxt;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // The partial sum lives in acc so result only changes at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cbout  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= (sub == OP_SUB) ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          carry <= cout_chunk;
          idx   <= idx + 1'b1;
          if (last) begin
            result <= final_res;
            cbout  <= cout_chunk;
            ovf    <= ovf_w;
            zero   <= (final_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
